// File: rtl/traffic_pkg.sv
// Shared encodings for the N-approach traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_e;

  // Lamp field order is {R,Y,G}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/tick_gen.sv
// Timing-tick prescaler: one-clk pulse every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic in_rst,
  output logic ou_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign ou_tick = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (in_rst || ou_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-approach traffic-light controller: round-robin service, demand-driven green,
// flashing-yellow fault mode.
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int unsigned N_WAY     = 4,
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YEL_TICKS = 2,
  parameter int unsigned RED_TICKS = 1,
  parameter int unsigned IDX_W     = $clog2(N_WAY)
) (
  input  logic                 clk,
  input  logic                 in_rst,
  input  logic [N_WAY-1:0]     in_req,
  input  logic                 in_flash,
  output logic [3*N_WAY-1:0]   ou_lamp,
  output logic [IDX_W-1:0]     ou_active,
  output logic [1:0]           ou_state
);

  localparam int unsigned T_MAX0 = (MAX_GREEN > YEL_TICKS) ? MAX_GREEN : YEL_TICKS;
  localparam int unsigned T_MAX  = (T_MAX0 > RED_TICKS) ? T_MAX0 : RED_TICKS;
  localparam int unsigned TW     = $clog2(T_MAX + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   active_q, active_d;
  logic [N_WAY-1:0]   pending_q, pending_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               lit_q, lit_d;
  logic               first_q, first_d;
  logic [3*N_WAY-1:0] lamp_q, lamp_d;

  logic               tick;
  logic [N_WAY-1:0]   act_oh, others, pend_next;
  logic [IDX_W-1:0]   sel;
  int unsigned        t_inc;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .in_rst  (in_rst),
    .ou_tick (tick)
  );

  // First pending approach after act (or from act itself when incl), else act.
  function automatic logic [IDX_W-1:0] rr_next(input logic [N_WAY-1:0] pend,
                                               input logic [IDX_W-1:0] act,
                                               input logic             incl);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = act;
    found = 1'b0;
    for (int unsigned k = 0; k < N_WAY; k++) begin
      idx = (32'(act) + k + {31'b0, ~incl}) % N_WAY;
      if (!found && (incl || k < N_WAY - 1) && pend[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    timer_d   = timer_q;
    lit_d     = lit_q;
    first_d   = first_q;
    act_oh    = N_WAY'(1) << active_q;
    others    = pending_q & ~act_oh;
    t_inc     = 32'(timer_q) + 32'd1;
    pend_next = pending_q | (in_req & ((state_q == ST_GREEN) ? ~act_oh : {N_WAY{1'b1}}));
    sel       = rr_next(pending_q, active_q, first_q);

    if (in_flash) begin
      if (state_q != ST_FLASH) begin
        state_d = ST_FLASH;
        lit_d   = 1'b1;
      end else if (tick) begin
        lit_d = ~lit_q;
      end
    end else begin
      unique case (state_q)
        ST_ALLRED: begin
          if (tick) begin
            if (t_inc >= RED_TICKS) begin
              state_d  = ST_GREEN;
              active_d = sel;
              timer_d  = '0;
              first_d  = 1'b0;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        ST_GREEN: begin
          if (tick) begin
            if (t_inc >= MIN_GREEN && |others && (!in_req[active_q] || t_inc >= MAX_GREEN)) begin
              state_d = ST_YELLOW;
              timer_d = '0;
            end else if (t_inc >= MAX_GREEN) begin
              timer_d = TW'(MAX_GREEN);
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        ST_YELLOW: begin
          if (tick) begin
            if (t_inc >= YEL_TICKS) begin
              state_d = ST_ALLRED;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        ST_FLASH: begin
          state_d = ST_ALLRED;
          timer_d = '0;
        end
      endcase
    end

    if (state_d == ST_FLASH || state_q == ST_FLASH) begin
      pending_d = '0;
    end else if (state_q == ST_ALLRED && state_d == ST_GREEN) begin
      pending_d = pend_next & ~(N_WAY'(1) << active_d);
    end else begin
      pending_d = pend_next;
    end

    // Lamps are decoded from next-state so the driver outputs come straight from flops.
    lamp_d = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (state_d == ST_FLASH) begin
        lamp_d[3*i +: 3] = lit_d ? LAMP_YEL : LAMP_OFF;
      end else if (IDX_W'(i) == active_d && state_d == ST_GREEN) begin
        lamp_d[3*i +: 3] = LAMP_GRN;
      end else if (IDX_W'(i) == active_d && state_d == ST_YELLOW) begin
        lamp_d[3*i +: 3] = LAMP_YEL;
      end else begin
        lamp_d[3*i +: 3] = LAMP_RED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      state_q   <= ST_ALLRED;
      active_q  <= '0;
      pending_q <= '0;
      timer_q   <= '0;
      lit_q     <= 1'b0;
      first_q   <= 1'b1;
      lamp_q    <= {N_WAY{LAMP_RED}};
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      lit_q     <= lit_d;
      first_q   <= first_d;
      lamp_q    <= lamp_d;
    end
  end

  assign ou_lamp   = lamp_q;
  assign ou_active = active_q;
  assign ou_state  = state_q;

endmodule

// File: doc/traffic_ctrl_n.md
# traffic_ctrl_n

Parametrised N-approach traffic-light controller with round-robin service of sensor requests. Green time is demand-driven: a minimum green, extension while the served approach keeps requesting, and a hard maximum. The block also provides an all-approach flashing-yellow fault mode. It sits between the board sensor inputs and the lamp drivers, and includes its own tick prescaler, so it runs directly from the board clock.

## Interface
- N_WAY, 4, number of approaches (2..16)
- TICK_DIV, 50_000_000, clk cycles per timing tick
- MIN_GREEN, 5, minimum green duration in ticks (≥1)
- MAX_GREEN, 20, maximum green duration in ticks when another approach is waiting (≥MIN_GREEN)
- YEL_TICKS, 2, yellow duration in ticks (≥1)
- RED_TICKS, 1, all-red clearance duration in ticks (≥1)
- IDX_W, $clog2(N_WAY), derived; not overridden
- clk  input  1  system clock; the only clock
- in_rst  input  1  reset, synchronous, active-high
- in_req  input  N_WAY  level sensor request, one bit per approach
- in_flash  input  1  level fault request: flashing-yellow mode while high
- ou_lamp  output  3*N_WAY  per approach i, bits [3i+2:3i] = {R,Y,G}
- ou_active  output  IDX_W  approach owning the current or last green
- ou_state  output  2  0 = ALLRED, 1 = GREEN, 2 = YELLOW, 3 = FLASH

## Operation
- Lamp codes: red 100, yellow 010, green 001, dark 000. Only the active approach is ever non-red outside FLASH.
- pending[N_WAY-1:0] is a sticky register.
  - pending[i] is set on any clk where in_req[i]=1, except when state=GREEN and active=i.
  - pending[active] is cleared on GREEN entry.
  - All pending bits are cleared in FLASH.
- Next-approach select: first set pending bit scanning active+1, active+2, … modulo N_WAY. The current approach is never chosen by the scan. If none is set, keep active.
- ALLRED: all lamps red. After RED_TICKS ticks, select the next approach, load it into active, and enter GREEN.
- GREEN: g_cnt counts ticks from 0 and saturates at MAX_GREEN.
  - Leave for YELLOW on a tick where all of the following hold: g_cnt+1 ≥ MIN_GREEN, some other pending bit is set, and (in_req[active]=0 or g_cnt+1 ≥ MAX_GREEN).
  - With no other approach pending, GREEN holds indefinitely.
- YELLOW: the active approach shows 010. After YEL_TICKS ticks, enter ALLRED.
- FLASH: entered from any state on the clk after in_flash=1.
  - All lamps alternate 010 and 000, toggling on each tick, starting lit.
  - On the clk after in_flash=0, enter ALLRED with the timer reloaded.
- Reset: state ALLRED, active=0, pending=0, timers and prescaler at 0. The first scan starts from index 0 inclusive.

## Timing
- The tick is a 1-clk pulse, asserted on the clk where the prescaler count reaches TICK_DIV-1. The count then wraps to 0.
- All state and output changes are registered and appear on the clk following the causing tick or input.
- Outputs are registered and glitch-free.
- Reset values: ou_lamp = all approaches 100, ou_active = 0, ou_state = 0.
- Reset asserted mid-cycle (any state) takes effect at the next clk edge and overrides in_flash.
- Simultaneous in_flash and a phase-expiry tick: FLASH wins.
- A request on the same clk as a GREEN-exit evaluation counts for that evaluation only if pending was already set. A new in_req becomes visible one clk later.
- Wrap-around: active = N_WAY-1 scans to 0 next.
- Timer width is $clog2(max(MAX_GREEN, YEL_TICKS, RED_TICKS)+1). g_cnt does not wrap.

## Structure
- Shared package traffic_pkg:
  - state encodings ST_ALLRED, ST_GREEN, ST_YELLOW, ST_FLASH
  - lamp constants LAMP_RED, LAMP_YEL, LAMP_GRN, LAMP_OFF
- Sub-module tick_gen (parameter TICK_DIV; ports clk, in_rst, ou_tick): prescaler only.
- The round-robin scan is a combinational function in traffic_ctrl_n. It is not a separate module.

## Test plan
All scenarios use TICK_DIV=4 and default durations.
- Reset with in_req=0: ALLRED for 1 tick, then approach 0 is 001 and the others are 100. The bench holds 100 ticks and checks GREEN is held, ou_active=0.
- Approach 0 green with no request; pulse in_req[2] and in_req[3] for 1 clk → 0 is green 5 ticks total, yellow 2, all-red 1, then 2 green 5 ticks, yellow/red, then 3 green and held.
- in_req[0] held high and in_req[1] pulsed → green 0 lasts exactly 20 ticks, then 1 is served.
- active=3 green; pulse in_req[1] → next green is 1; 0 and 2 remain 100 throughout.
- in_flash=1 mid-GREEN → next clk all lamps 010, toggling each tick, pending cleared. in_flash=0 → ALLRED 1 tick, then green to ou_active+1 if pending, else same.
- in_rst=1 for 1 clk during YELLOW → next clk all 100, ou_state=0, ou_active=0; normal sequence resumes from index 0.
